// File: rtl/game_state_tracker_if.sv
// Coordinate inputs and game-state outputs shared between the sprite movers,
// the tracker and color_mapper. The tracker sits on the slave side.
interface game_state_tracker_if #(
    parameter int unsigned NUM_GHOSTS = 3,
    parameter int unsigned NUM_FRUITS = 3,
    parameter int unsigned LIVES_W    = 2,
    parameter int unsigned SCORE_W    = 16
);
    logic                       frame_vs;
    logic [9:0]                 pacman_x;
    logic [9:0]                 pacman_y;
    logic [10*NUM_GHOSTS-1:0]   ghost_x;
    logic [10*NUM_GHOSTS-1:0]   ghost_y;
    logic [10*NUM_FRUITS-1:0]   fruit_x;
    logic [10*NUM_FRUITS-1:0]   fruit_y;
    logic [LIVES_W-1:0]         lives;
    logic [NUM_FRUITS-1:0]      fruit_on;
    logic [SCORE_W-1:0]         score;
    logic                       hit;
    logic                       grace;
    logic                       game_over;
    logic                       win;
    logic                       busy;

    modport master (
        output frame_vs, pacman_x, pacman_y, ghost_x, ghost_y, fruit_x, fruit_y,
        input  lives, fruit_on, score, hit, grace, game_over, win, busy
    );

    modport slave (
        input  frame_vs, pacman_x, pacman_y, ghost_x, ghost_y, fruit_x, fruit_y,
        output lives, fruit_on, score, hit, grace, game_over, win, busy
    );
endinterface

// File: rtl/game_state_tracker.sv
// Per-frame game-state engine: one shared squared-distance pipeline tests Pacman
// against every ghost and fruit, then lives/fruits/score/grace/flags are resolved.
module game_state_tracker #(
    parameter int unsigned NUM_GHOSTS   = 3,
    parameter int unsigned NUM_FRUITS   = 3,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned LIVES_W      = 2,
    parameter int unsigned HIT_R2       = 64,
    parameter int unsigned FRUIT_R2     = 64,
    parameter int unsigned GRACE_FRAMES = 60,
    parameter int unsigned FRUIT_POINTS = 50,
    parameter int unsigned SCORE_W      = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic restart,
    game_state_tracker_if.slave io
);
    localparam int unsigned N  = NUM_GHOSTS + NUM_FRUITS;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, RESOLVE, DONE} state_t;

    state_t                 state;
    logic                   vs_q;
    logic                   vs_rise;
    logic [9:0]             pac_x_s;
    logic [9:0]             pac_y_s;
    logic [9:0]             snap_x [N];
    logic [9:0]             snap_y [N];
    logic [CW-1:0]          idx;
    logic                   drain_cnt;

    logic                   v1;
    logic                   v2;
    logic [CW-1:0]          ch1;
    logic [CW-1:0]          ch2;
    logic signed [10:0]     dx;
    logic signed [10:0]     dy;
    logic signed [21:0]     sqx;
    logic signed [21:0]     sqy;
    logic [20:0]            d2;

    logic                   hit_flag;
    logic [NUM_FRUITS-1:0]  eat;
    logic [GW-1:0]          grace_cnt;

    logic [LIVES_W-1:0]     lives_q;
    logic [NUM_FRUITS-1:0]  fruit_on_q;
    logic [SCORE_W-1:0]     score_q;
    logic                   hit_q;
    logic                   game_over_q;
    logic                   win_q;
    logic                   busy_q;

    logic [9:0]             sel_x;
    logic [9:0]             sel_y;
    logic                   ghost_near;
    logic [NUM_FRUITS-1:0]  eat_set;
    logic [NUM_FRUITS-1:0]  fruit_next;
    int unsigned            eat_cnt;
    logic [SCORE_W:0]       score_sum;
    logic [SCORE_W-1:0]     score_next;
    logic                   hit_take;
    logic [LIVES_W-1:0]     lives_dec;

    assign vs_rise      = io.frame_vs & ~vs_q;
    assign io.lives     = lives_q;
    assign io.fruit_on  = fruit_on_q;
    assign io.score     = score_q;
    assign io.hit       = hit_q;
    assign io.grace     = (grace_cnt != '0);
    assign io.game_over = game_over_q;
    assign io.win       = win_q;
    assign io.busy      = busy_q;

    always_comb begin
        sel_x = snap_x[idx];
        sel_y = snap_y[idx];
        sqx   = dx * dx;
        sqy   = dy * dy;

        // Results leave stage 2 in channel order; ghosts occupy the low channels.
        ghost_near = 1'b0;
        eat_set    = '0;
        if (v2) begin
            if (ch2 < CW'(NUM_GHOSTS))
                ghost_near = ({11'b0, d2} < HIT_R2);
            for (int unsigned i = 0; i < NUM_FRUITS; i++)
                if (ch2 == CW'(NUM_GHOSTS + i) && ({11'b0, d2} < FRUIT_R2) && fruit_on_q[i])
                    eat_set[i] = 1'b1;
        end

        fruit_next = fruit_on_q & ~eat;
        eat_cnt    = 0;
        for (int unsigned i = 0; i < NUM_FRUITS; i++)
            eat_cnt = eat_cnt + 32'(eat[i]);
        score_sum  = {1'b0, score_q} + (SCORE_W+1)'(FRUIT_POINTS * eat_cnt);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        hit_take   = hit_flag && (grace_cnt == '0);
        lives_dec  = lives_q - LIVES_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            vs_q        <= 1'b1;
            pac_x_s     <= '0;
            pac_y_s     <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
            idx         <= '0;
            drain_cnt   <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            ch1         <= '0;
            ch2         <= '0;
            dx          <= '0;
            dy          <= '0;
            d2          <= '0;
            hit_flag    <= 1'b0;
            eat         <= '0;
            grace_cnt   <= '0;
            lives_q     <= LIVES_W'(START_LIVES);
            fruit_on_q  <= '1;
            score_q     <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vs_q  <= io.frame_vs;
            hit_q <= 1'b0;
            if (restart) begin
                state       <= IDLE;
                idx         <= '0;
                drain_cnt   <= 1'b0;
                v1          <= 1'b0;
                v2          <= 1'b0;
                hit_flag    <= 1'b0;
                eat         <= '0;
                grace_cnt   <= '0;
                lives_q     <= LIVES_W'(START_LIVES);
                fruit_on_q  <= '1;
                score_q     <= '0;
                game_over_q <= 1'b0;
                win_q       <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                v1       <= (state == SCAN);
                ch1      <= idx;
                dx       <= {1'b0, pac_x_s} - {1'b0, sel_x};
                dy       <= {1'b0, pac_y_s} - {1'b0, sel_y};
                v2       <= v1;
                ch2      <= ch1;
                d2       <= 21'(sqx + sqy);
                hit_flag <= hit_flag | ghost_near;
                eat      <= eat | eat_set;

                case (state)
                    IDLE: begin
                        if (vs_rise) begin
                            pac_x_s <= io.pacman_x;
                            pac_y_s <= io.pacman_y;
                            for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
                                snap_x[i] <= io.ghost_x[10*i +: 10];
                                snap_y[i] <= io.ghost_y[10*i +: 10];
                            end
                            for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
                                snap_x[NUM_GHOSTS+i] <= io.fruit_x[10*i +: 10];
                                snap_y[NUM_GHOSTS+i] <= io.fruit_y[10*i +: 10];
                            end
                            if (grace_cnt != '0)
                                grace_cnt <= grace_cnt - GW'(1);
                            hit_flag <= 1'b0;
                            eat      <= '0;
                            idx      <= '0;
                            busy_q   <= 1'b1;
                            state    <= SCAN;
                        end
                    end
                    SCAN: begin
                        idx <= idx + CW'(1);
                        if (idx == CW'(N - 1)) begin
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt)
                            state <= RESOLVE;
                        else
                            drain_cnt <= 1'b1;
                    end
                    RESOLVE: begin
                        fruit_on_q <= fruit_next;
                        score_q    <= score_next;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                        if (hit_take) begin
                            hit_q   <= 1'b1;
                            lives_q <= lives_dec;
                            if (lives_dec == '0) begin
                                game_over_q <= 1'b1;
                                state       <= DONE;
                            end else begin
                                grace_cnt <= GW'(GRACE_FRAMES);
                            end
                        end
                        // game_over outranks win when both happen in one frame.
                        if (fruit_next == '0 && !(hit_take && lives_dec == '0)) begin
                            win_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_game_state_tracker.sv
// Bench for game_state_tracker: directed scenarios plus randomized frames checked
// against a frame-level reference model of the game rules.
module tb_game_state_tracker;
    localparam int NG = 3;
    localparam int NF = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    always #5 clk = ~clk;

    game_state_tracker_if #(.NUM_GHOSTS(NG), .NUM_FRUITS(NF), .LIVES_W(2), .SCORE_W(16)) bus ();

    game_state_tracker #(
        .NUM_GHOSTS(NG), .NUM_FRUITS(NF), .START_LIVES(3), .LIVES_W(2),
        .HIT_R2(64), .FRUIT_R2(64), .GRACE_FRAMES(60), .FRUIT_POINTS(50), .SCORE_W(16)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .restart(restart), .io(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    int px, py;
    int gx [NG];
    int gy [NG];
    int fx [NF];
    int fy [NF];

    int       m_lives, m_score, m_grace;
    bit [2:0] m_fruit;
    bit       m_over, m_win;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = 3; m_score = 0; m_grace = 0; m_fruit = 3'b111; m_over = 0; m_win = 0;
    endtask

    function automatic int dist2(int ax, int ay, int bx, int by);
        return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
    endfunction

    // One frame of the game rules, applied to the coordinates seen at the edge.
    task automatic model_frame(output bit active, output bit exp_hit);
        bit hf;
        int cnt;
        exp_hit = 0;
        active  = !(m_over || m_win);
        if (!active) return;
        if (m_grace > 0) m_grace--;
        hf = 0;
        for (int i = 0; i < NG; i++)
            if (dist2(px, py, gx[i], gy[i]) < 64) hf = 1;
        cnt = 0;
        for (int i = 0; i < NF; i++)
            if (m_fruit[i] && dist2(px, py, fx[i], fy[i]) < 64) begin
                m_fruit[i] = 0;
                cnt++;
            end
        m_score = m_score + 50 * cnt;
        if (m_score > 65535) m_score = 65535;
        if (hf && m_grace == 0) begin
            exp_hit = 1;
            m_lives--;
            if (m_lives == 0) m_over = 1;
            else m_grace = 60;
        end
        if (m_fruit == 0 && !m_over) m_win = 1;
    endtask

    task automatic drive_coords();
        bus.pacman_x = 10'(px);
        bus.pacman_y = 10'(py);
        for (int i = 0; i < NG; i++) begin
            bus.ghost_x[10*i +: 10] = 10'(gx[i]);
            bus.ghost_y[10*i +: 10] = 10'(gy[i]);
        end
        for (int i = 0; i < NF; i++) begin
            bus.fruit_x[10*i +: 10] = 10'(fx[i]);
            bus.fruit_y[10*i +: 10] = 10'(fy[i]);
        end
    endtask

    task automatic set_far();
        for (int i = 0; i < NG; i++) begin gx[i] = 900 + 40 * i; gy[i] = 900; end
        for (int i = 0; i < NF; i++) begin fx[i] = 600 + 50 * i; fy[i] = 650; end
    endtask

    function automatic int near(int c);
        int v;
        v = c + int'($urandom_range(0, 20)) - 10;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    task automatic check_state();
        check_eq("lives", 32'(bus.lives), 32'(m_lives));
        check_eq("fruit_on", 32'(bus.fruit_on), 32'(m_fruit));
        check_eq("score", 32'(bus.score), 32'(m_score));
        check_eq("grace", 32'(bus.grace), 32'(m_grace != 0));
        check_eq("game_over", 32'(bus.game_over), 32'(m_over));
        check_eq("win", 32'(bus.win), 32'(m_win));
    endtask

    task automatic check_reset_vals();
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_hit", 32'(bus.hit), 0);
        check_eq("rst_lives", 32'(bus.lives), 3);
        check_eq("rst_fruit_on", 32'(bus.fruit_on), 7);
        check_eq("rst_score", 32'(bus.score), 0);
        check_eq("rst_grace", 32'(bus.grace), 0);
        check_eq("rst_game_over", 32'(bus.game_over), 0);
        check_eq("rst_win", 32'(bus.win), 0);
    endtask

    task automatic do_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        model_reset();
        check_reset_vals();
    endtask

    // Full frame: rising edge, 9 busy cycles, results and hit pulse, pulse clear.
    task automatic run_frame(input bit drop_edge, input bit scramble);
        bit active, eh;
        @(negedge clk); bus.frame_vs = 1'b0;
        @(negedge clk); drive_coords(); bus.frame_vs = 1'b1;
        model_frame(active, eh);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_eq("busy", 32'(bus.busy), 32'(active));
            check_eq("hit_during_scan", 32'(bus.hit), 0);
            if (scramble && c == 1) begin
                bus.pacman_x = 10'($urandom_range(0, 1023));
                bus.ghost_x  = 30'($urandom);
                bus.fruit_y  = 30'($urandom);
            end
            if (drop_edge && c == 3) bus.frame_vs = 1'b0;
            if (drop_edge && c == 4) bus.frame_vs = 1'b1;
        end
        @(negedge clk);
        check_eq("busy_end", 32'(bus.busy), 0);
        check_eq("hit", 32'(bus.hit), 32'(eh));
        if (bus.hit === 1'b1) pulses++;
        check_state();
        @(negedge clk);
        check_eq("hit_clear", 32'(bus.hit), 0);
    endtask

    initial begin
        bus.frame_vs = 1'b1;
        px = 184; py = 80;
        set_far();
        drive_coords();
        model_reset();

        // Reset released with frame_vs high: no spurious frame.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(bus.busy), 0);
        end
        check_reset_vals();

        // Fruit 0 under Pacman.
        fx[0] = 184; fy[0] = 80;
        run_frame(0, 0);
        check_eq("t2_fruit_on", 32'(bus.fruit_on), 6);
        check_eq("t2_score", 32'(bus.score), 50);
        run_frame(0, 0);
        check_eq("t2_score_hold", 32'(bus.score), 50);

        // Restart mid-scan, then a normal frame.
        gx[0] = 184; gy[0] = 80;
        @(negedge clk); bus.frame_vs = 1'b0;
        @(negedge clk); drive_coords(); bus.frame_vs = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_busy_mid", 32'(bus.busy), 1);
        restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        model_reset();
        check_reset_vals();
        set_far();
        fx[0] = 184; fy[0] = 80;
        run_frame(0, 0);
        check_eq("t6_score", 32'(bus.score), 50);

        // Radius boundary: 49 hits, 64 does not.
        do_restart();
        px = 300; py = 300; set_far();
        gx[1] = 307; gy[1] = 300;
        run_frame(0, 0);
        check_eq("t3_lives", 32'(bus.lives), 2);
        check_eq("t3_grace", 32'(bus.grace), 1);
        do_restart();
        gx[1] = 308;
        run_frame(0, 0);
        check_eq("t3_edge_lives", 32'(bus.lives), 3);

        // Continuous overlap for 70 frames: two counted hits.
        do_restart();
        set_far();
        gx[0] = 300; gy[0] = 300;
        pulses = 0;
        for (int f = 0; f < 70; f++) run_frame(0, 0);
        check_eq("t4_pulses", 32'(pulses), 2);
        check_eq("t4_lives", 32'(bus.lives), 1);

        // Last life: eat two fruits, wait out grace, then hit while eating the last.
        set_far();
        fx[0] = 300; fy[0] = 300; fx[1] = 300; fy[1] = 300;
        run_frame(0, 0);
        for (int f = 0; f < 70 && m_grace > 1; f++) run_frame(0, 0);
        gx[0] = 300; gy[0] = 300; fx[2] = 300; fy[2] = 300;
        run_frame(0, 0);
        check_eq("t5_lives", 32'(bus.lives), 0);
        check_eq("t5_game_over", 32'(bus.game_over), 1);
        check_eq("t5_win", 32'(bus.win), 0);
        check_eq("t5_fruit_on", 32'(bus.fruit_on), 0);
        check_eq("t5_score", 32'(bus.score), 150);
        for (int f = 0; f < 3; f++) run_frame(0, 0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 250; f++) begin
            if (m_over || m_win || $urandom_range(0, 49) == 0) do_restart();
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            for (int i = 0; i < NG; i++) begin
                if ($urandom_range(0, 7) == 0) begin gx[i] = near(px); gy[i] = near(py); end
                else begin gx[i] = int'($urandom_range(0, 1023)); gy[i] = int'($urandom_range(0, 1023)); end
            end
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 2) == 0) begin fx[i] = near(px); fy[i] = near(py); end
                else begin fx[i] = int'($urandom_range(0, 1023)); fy[i] = int'($urandom_range(0, 1023)); end
            end
            run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
